i2s_sample_tx: RTL and testbench

Audio sample transmitter for the MAX9850 DAC, mapped beside the I2C control block on the CPU bus. The CPU pushes stereo 16-bit sample pairs into a small FIFO. The block serializes them as standard Philips I2S: BCLK, LRCLK, SDATA, 32 BCLK per frame, MSB first, data one BCLK after the LRCLK edge. The I2C block configures the codec; this block feeds it audio.

---
 rtl/i2s_sample_tx.sv | 137 +++++++++++++
 tb/tb_i2s_sample_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: CPU-fed stereo sample FIFO plus Philips I2S serializer
// (BCLK, LRCLK, SDATA; 32 BCLK per frame, MSB first, data one BCLK after
// the LRCLK edge).
// Build option: define I2S_TX_UNDERRUN_REPEAT_EN to resend the last popped
// word on underrun; by default an underrun frame carries silence.
module i2s_sample_tx #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int CLK_DIV         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr,
  input  logic [31:0]                i_wdata,
  input  logic                       i_enable,
  input  logic                       i_underrun_clr,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [FIFO_DEPTH_LOG2:0]   o_level,
  output logic                       o_underrun,
  output logic                       o_bclk,
  output logic                       o_lrclk,
  output logic                       o_sdata
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  logic [31:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;

  logic [DW-1:0]              div_cnt;
  logic [4:0]                 slot;
  logic [31:0]                shreg;
  state_t                     state;

  logic                       div_wrap;
  logic                       fall;
  logic                       slot0_entry;
  logic                       pop;
  logic                       push;
  logic [31:0]                underrun_word;
  logic [31:0]                load_word;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [31:0]                last_word;

  // Remember the last word handed to the serializer for underrun repeat.
  always_ff @(posedge clk) begin
    if (rst)      last_word <= '0;
    else if (pop) last_word <= mem[rd_ptr];
  end

  assign underrun_word = last_word;
`else
  assign underrun_word = '0;
`endif

  assign o_empty = (count == '0);
  assign o_full  = (count == (FIFO_DEPTH_LOG2+1)'(DEPTH));
  assign o_level = count;

  // Frame-boundary decode: a falling BCLK event either starts the first
  // frame after enable (IDLE) or wraps slot 31 back to slot 0.
  always_comb begin
    div_wrap    = i_enable && (div_cnt == DW'(CLK_DIV - 1));
    fall        = div_wrap && o_bclk;
    slot0_entry = fall && ((state == IDLE) || (slot == 5'd31));
    pop         = slot0_entry && !o_empty;
    push        = i_wr && (!o_full || pop);
    load_word   = pop ? mem[rd_ptr] : underrun_word;
  end

  // Sample storage; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_wdata;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky underrun flag; a set wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                                o_underrun <= 1'b0;
    else if (slot0_entry && o_empty)        o_underrun <= 1'b1;
    else if (i_underrun_clr)                o_underrun <= 1'b0;
  end

  // BCLK divider and slot/shift state machine; disable drops the frame.
  always_ff @(posedge clk) begin
    if (rst || !i_enable) begin
      state   <= IDLE;
      div_cnt <= '0;
      slot    <= '0;
      shreg   <= '0;
      o_bclk  <= 1'b0;
      o_lrclk <= 1'b0;
      o_sdata <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) o_bclk <= ~o_bclk;
      if (fall) begin
        if (slot0_entry) begin
          state   <= RUN;
          slot    <= '0;
          o_sdata <= load_word[31];
          shreg   <= {load_word[30:0], 1'b0};
          o_lrclk <= 1'b0;
        end else begin
          slot    <= slot + 5'd1;
          o_sdata <= shreg[31];
          shreg   <= {shreg[30:0], 1'b0};
          // Entering slot+1: high for slots 15..30.
          o_lrclk <= (slot >= 5'd14) && (slot <= 5'd29);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Testbench for i2s_sample_tx: frame-level reference model (queue of words,
// BCLK/slot derived arithmetically from enabled-cycle count), per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_i2s_sample_tx;

  localparam int LOG2  = 4;
  localparam int CD    = 4;
  localparam int DEPTH = 1 << LOG2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr;
  logic [31:0]   i_wdata;
  logic          i_enable;
  logic          i_underrun_clr;
  logic          o_full;
  logic          o_empty;
  logic [LOG2:0] o_level;
  logic          o_underrun;
  logic          o_bclk;
  logic          o_lrclk;
  logic          o_sdata;

  int checks = 0;
  int errors = 0;

  i2s_sample_tx #(.FIFO_DEPTH_LOG2(LOG2), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .i_wr(i_wr), .i_wdata(i_wdata),
    .i_enable(i_enable), .i_underrun_clr(i_underrun_clr),
    .o_full(o_full), .o_empty(o_empty), .o_level(o_level),
    .o_underrun(o_underrun), .o_bclk(o_bclk), .o_lrclk(o_lrclk),
    .o_sdata(o_sdata)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] mq[$];
  int          k = 0;          // consecutive clk edges with enable high
  logic [31:0] cur = '0;       // word of the current frame
  logic [31:0] last = '0;      // last popped word
  logic        m_under = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); k = 0; cur = '0; last = '0; m_under = 1'b0;
    end else begin
      logic set;
      logic popped;
      set = 1'b0;
      popped = 1'b0;
      if (i_enable) begin
        k++;
        if ((k % (2*CD)) == 0 && (((k / (2*CD)) - 1) % 32) == 0) begin
          if (mq.size() > 0) begin
            cur = mq.pop_front();
            last = cur;
            popped = 1'b1;
          end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            cur = last;
`else
            cur = '0;
`endif
            set = 1'b1;
          end
        end
      end else begin
        k = 0;
      end
      if (i_wr && mq.size() < DEPTH) mq.push_back(i_wdata);
      if (set) m_under = 1'b1;
      else if (i_underrun_clr) m_under = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare on the falling clk edge.
  always @(negedge clk) begin
    int m;
    int s;
    logic e_bclk;
    logic e_lr;
    logic e_sd;
    e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0;
    if (k > 0) begin
      e_bclk = ((k / CD) % 2) == 1;
      m = k / (2*CD);
      if (m > 0) begin
        s = (m - 1) % 32;
        e_sd = cur[31 - s];
        e_lr = (s >= 15) && (s <= 30);
      end
    end
    check("level",    32'(o_level),    32'(mq.size()));
    check("empty",    32'(o_empty),    32'(mq.size() == 0));
    check("full",     32'(o_full),     32'(mq.size() == DEPTH));
    check("underrun", 32'(o_underrun), 32'(m_under));
    check("bclk",     32'(o_bclk),     32'(e_bclk));
    check("lrclk",    32'(o_lrclk),    32'(e_lr));
    check("sdata",    32'(o_sdata),    32'(e_sd));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [31:0] w);
    i_wr = 1'b1; i_wdata = w;
    tick(1);
    i_wr = 1'b0;
  endtask

  initial begin
    logic [31:0] sd_cap;
    logic [31:0] lr_cap;
    rst = 1'b1; i_wr = 1'b0; i_wdata = '0; i_enable = 1'b0; i_underrun_clr = 1'b0;
    tick(3);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_lines", {29'd0, o_bclk, o_lrclk, o_sdata}, 32'd0);
    rst = 1'b0;
    tick(1);

    // One word, then enable: literal frame capture.
    write_word(32'hA5A5_3C3C);
    i_enable = 1'b1;
    tick(3);
    check("bclk_low_T3", 32'(o_bclk), 32'd0);
    tick(1);
    check("bclk_rise_T4", 32'(o_bclk), 32'd1);
    tick(3);
    check("level_T7", 32'(o_level), 32'd1);
    tick(1);
    check("level_T8", 32'(o_level), 32'd0);
    sd_cap = '0; lr_cap = '0;
    for (int s = 0; s < 32; s++) begin
      if (s > 0) tick(8);
      sd_cap[31 - s] = o_sdata;
      lr_cap[31 - s] = o_lrclk;
    end
    check("frame_sdata", sd_cap, 32'hA5A5_3C3C);
    check("frame_lrclk", lr_cap, 32'h0001_FFFE);
    i_enable = 1'b0;
    tick(2);

    // Empty enable; clear pulse coincides with the underrun-setting entry.
    i_enable = 1'b1;
    tick(7);
    i_underrun_clr = 1'b1;
    tick(1);
    i_underrun_clr = 1'b0;
    check("under_set_wins", 32'(o_underrun), 32'd1);
    write_word(32'h8001_7FFE);
    tick(2);
    i_underrun_clr = 1'b1;
    tick(1);
    i_underrun_clr = 1'b0;
    check("under_cleared", 32'(o_underrun), 32'd0);
    tick(3 * 64 * CD);
    i_enable = 1'b0;
    i_underrun_clr = 1'b1;
    tick(1);
    i_underrun_clr = 1'b0;

    // Fill with 17 words while disabled.
    for (int i = 1; i <= 17; i++) write_word(32'(i) * 32'h0101_0101);
    tick(1);
    check("fill_full",  32'(o_full),  32'd1);
    check("fill_level", 32'(o_level), 32'd16);

    // Enable; a write coincides with the first pop.
    i_enable = 1'b1;
    tick(7);
    i_wr = 1'b1; i_wdata = 32'hDEAD_BEEF;
    tick(1);
    i_wr = 1'b0;
    check("coinc_level", 32'(o_level), 32'd16);
    check("coinc_full",  32'(o_full),  32'd1);

    // Drop enable while in slot 10.
    tick(80);
    i_enable = 1'b0;
    tick(1);
    check("dis_lines", {29'd0, o_bclk, o_lrclk, o_sdata}, 32'd0);
    check("dis_level", 32'(o_level), 32'd16);
    i_enable = 1'b1;
    tick(2 * 64 * CD);

    // Randomized traffic.
    for (int c = 0; c < 8000; c++) begin
      i_wr = ($urandom_range(0, 99) < 2);
      i_wdata = $urandom;
      i_underrun_clr = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 699) == 0) i_enable = ~i_enable;
      tick(1);
    end
    i_wr = 1'b0; i_underrun_clr = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
